// File: rtl/nebula_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nebula_pkg
// Purpose  : Flit types, head-field layout and error-bit indices for the
//            nebula NoC packet bridge.
// Revision : 1.0
// ============================================================================
package nebula_pkg;

   typedef enum logic [1:0] {
      FLIT_HEAD   = 2'b00,
      FLIT_BODY   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   localparam int ERR_DEST_MISMATCH = 0;
   localparam int ERR_PROTOCOL      = 1;
   localparam int ERR_BAD_LEN       = 2;

   localparam int HF_DEST_X = 0;

   function automatic int coord_width(input int size_x, input int size_y);
      int m;
      m = (size_x > size_y) ? size_x : size_y;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

   // Head payload layout, LSB first: dest_x, dest_y, src_x, src_y, len, ts
   function automatic int hf_dest_y(input int cw);
      return cw;
   endfunction

   function automatic int hf_src_x(input int cw);
      return 2 * cw;
   endfunction

   function automatic int hf_src_y(input int cw);
      return 3 * cw;
   endfunction

   function automatic int hf_len(input int cw);
      return 4 * cw;
   endfunction

   function automatic int hf_ts(input int cw, input int lw);
      return 4 * cw + lw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nebula_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nebula_sync_fifo
// Purpose  : Single-clock FIFO with first-word-fall-through read port.
// Revision : 1.0
// ============================================================================
module nebula_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_do_pop  = pop && !empty;
   // A push into a full FIFO is only legal when the same-cycle pop frees a slot
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   assign rdata = r_mem[r_rd_ptr];
   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/nebula_noc_packet_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nebula_noc_packet_bridge
// Purpose  : NoC endpoint: packetises local sends, buffers/parses router flits.
//            Define NEBULA_BRIDGE_LATENCY_EN for timestamping and latency averaging.
// Revision : 1.0
// ============================================================================
module nebula_noc_packet_bridge
   import nebula_pkg::*;
#(
   parameter int NODE_X            = 0,
   parameter int NODE_Y            = 0,
   parameter int MESH_SIZE_X       = 4,
   parameter int MESH_SIZE_Y       = 4,
   parameter int DATA_WIDTH        = 64,
   parameter int MAX_PAYLOAD_FLITS = 4,
   parameter int RX_FIFO_DEPTH     = 8,
   parameter int TS_WIDTH          = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic tx_req_valid,
   output logic tx_req_ready,
   input  logic [coord_width(MESH_SIZE_X, MESH_SIZE_Y)-1:0] tx_req_dest_x,
   input  logic [coord_width(MESH_SIZE_X, MESH_SIZE_Y)-1:0] tx_req_dest_y,
   input  logic [$clog2(MAX_PAYLOAD_FLITS+1)-1:0]           tx_req_len,
   input  logic [MAX_PAYLOAD_FLITS*DATA_WIDTH-1:0]          tx_req_data,
   output logic noc_flit_out_valid,
   input  logic noc_flit_out_ready,
   output logic [DATA_WIDTH+1:0] noc_flit_out,
   input  logic noc_flit_in_valid,
   output logic noc_flit_in_ready,
   input  logic [DATA_WIDTH+1:0] noc_flit_in,
   output logic rx_valid,
   input  logic rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic [coord_width(MESH_SIZE_X, MESH_SIZE_Y)-1:0] rx_src_x,
   output logic [coord_width(MESH_SIZE_X, MESH_SIZE_Y)-1:0] rx_src_y,
   output logic rx_last,
   input  logic err_clr,
   output logic [31:0] packet_tx_count,
   output logic [31:0] packet_rx_count,
   output logic [15:0] avg_latency,
   output logic [7:0]  buffer_utilization,
   output logic [31:0] error_reg
);

   localparam int CW        = coord_width(MESH_SIZE_X, MESH_SIZE_Y);
   localparam int LW        = $clog2(MAX_PAYLOAD_FLITS + 1);
   localparam int FW        = DATA_WIDTH + 2;
   localparam int HF_DEST_Y = hf_dest_y(CW);
   localparam int HF_SRC_X  = hf_src_x(CW);
   localparam int HF_SRC_Y  = hf_src_y(CW);
   localparam int HF_LEN    = hf_len(CW);
   localparam int HF_TS     = hf_ts(CW, LW);

   localparam logic [1:0] TX_IDLE    = 2'd0;
   localparam logic [1:0] TX_HEAD    = 2'd1;
   localparam logic [1:0] TX_PAYLOAD = 2'd2;

   localparam logic [1:0] RX_WAIT_HEAD = 2'd0;
   localparam logic [1:0] RX_DELIVER   = 2'd1;
   localparam logic [1:0] RX_DROP      = 2'd2;

   logic [1:0]                            r_tx_state, w_tx_next;
   logic [CW-1:0]                         r_tx_dx, r_tx_dy;
   logic [LW-1:0]                         r_tx_len, r_tx_idx;
   logic [MAX_PAYLOAD_FLITS*DATA_WIDTH-1:0] r_tx_data;
   logic [TS_WIDTH-1:0]                   r_tx_ts, w_head_ts;
   logic [DATA_WIDTH-1:0]                 w_head_pay;
   logic                                  w_bad_len, w_out_hs, w_tx_last, w_tx_done;
   logic [31:0]                           r_tx_count, r_rx_count, r_err, w_err_set;

   logic [1:0]          r_rx_state, w_rx_next;
   logic [FW-1:0]       w_fifo_q;
   logic                w_full, w_empty, w_pop;
   logic [$clog2(RX_FIFO_DEPTH):0] w_count;
   flit_type_e          w_ftype;
   logic [DATA_WIDTH-1:0] w_fpay;
   logic                w_is_head, w_dest_ok, w_head_take, w_rx_done;
   logic                w_rx_dest_err, w_rx_proto_err;
   logic [CW-1:0]       r_rx_sx, r_rx_sy;
   logic [LW-1:0]       r_rx_len;
   logic [TS_WIDTH-1:0] r_rx_ts, w_done_ts;

   // ---------------------------------------------------------------- egress
   assign w_bad_len = (tx_req_len > LW'(MAX_PAYLOAD_FLITS));
   assign w_out_hs  = noc_flit_out_valid && noc_flit_out_ready;
   assign w_tx_last = (r_tx_idx == r_tx_len - 1'b1);
   assign w_tx_done = w_out_hs && (((r_tx_state == TX_HEAD) && (r_tx_len == '0)) ||
                                   ((r_tx_state == TX_PAYLOAD) && w_tx_last));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tx_state <= TX_IDLE;
      else     r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:    if (tx_req_valid && !w_bad_len) w_tx_next = TX_HEAD;
         TX_HEAD:    if (w_out_hs) w_tx_next = (r_tx_len == '0) ? TX_IDLE : TX_PAYLOAD;
         TX_PAYLOAD: if (w_out_hs && w_tx_last) w_tx_next = TX_IDLE;
         default:    w_tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_req_ready       = 1'b0;
      noc_flit_out_valid = 1'b0;
      noc_flit_out       = '0;
      w_head_pay         = '0;
      w_head_pay[HF_DEST_X +: CW]      = r_tx_dx;
      w_head_pay[HF_DEST_Y +: CW]      = r_tx_dy;
      w_head_pay[HF_SRC_X  +: CW]      = CW'(NODE_X);
      w_head_pay[HF_SRC_Y  +: CW]      = CW'(NODE_Y);
      w_head_pay[HF_LEN    +: LW]      = r_tx_len;
      w_head_pay[HF_TS     +: TS_WIDTH] = r_tx_ts;
      case (r_tx_state)
         TX_IDLE: tx_req_ready = 1'b1;
         TX_HEAD: begin
            noc_flit_out_valid = 1'b1;
            noc_flit_out = {w_head_pay, (r_tx_len == '0) ? FLIT_SINGLE : FLIT_HEAD};
         end
         TX_PAYLOAD: begin
            noc_flit_out_valid = 1'b1;
            noc_flit_out = {r_tx_data[int'(r_tx_idx)*DATA_WIDTH +: DATA_WIDTH],
                            w_tx_last ? FLIT_TAIL : FLIT_BODY};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_dx    <= '0;
         r_tx_dy    <= '0;
         r_tx_len   <= '0;
         r_tx_data  <= '0;
         r_tx_ts    <= '0;
         r_tx_idx   <= '0;
         r_tx_count <= '0;
      end else begin
         if (tx_req_valid && tx_req_ready && !w_bad_len) begin
            r_tx_dx   <= tx_req_dest_x;
            r_tx_dy   <= tx_req_dest_y;
            r_tx_len  <= tx_req_len;
            r_tx_data <= tx_req_data;
            r_tx_ts   <= w_head_ts;
         end
         if ((r_tx_state == TX_HEAD) && w_out_hs)         r_tx_idx <= '0;
         else if ((r_tx_state == TX_PAYLOAD) && w_out_hs) r_tx_idx <= r_tx_idx + 1'b1;
         if (w_tx_done) r_tx_count <= r_tx_count + 1'b1;
      end
   end

   // --------------------------------------------------------------- ingress
   nebula_sync_fifo #(.WIDTH(FW), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (noc_flit_in_valid && noc_flit_in_ready),
      .wdata (noc_flit_in),
      .pop   (w_pop),
      .rdata (w_fifo_q),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   assign noc_flit_in_ready = !w_full;
   assign w_ftype   = flit_type_e'(w_fifo_q[1:0]);
   assign w_fpay    = w_fifo_q[FW-1:2];
   assign w_is_head = (w_ftype == FLIT_HEAD) || (w_ftype == FLIT_SINGLE);
   assign w_dest_ok = (w_fpay[HF_DEST_X +: CW] == CW'(NODE_X)) &&
                      (w_fpay[HF_DEST_Y +: CW] == CW'(NODE_Y));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rx_state <= RX_WAIT_HEAD;
      else     r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_WAIT_HEAD:
            if (!w_empty && (w_ftype == FLIT_HEAD)) w_rx_next = w_dest_ok ? RX_DELIVER : RX_DROP;
         RX_DELIVER:
            if (!w_empty && (w_ftype == FLIT_TAIL) && rx_ready) w_rx_next = RX_WAIT_HEAD;
         RX_DROP:
            if (!w_empty && (w_ftype == FLIT_TAIL)) w_rx_next = RX_WAIT_HEAD;
         default: w_rx_next = RX_WAIT_HEAD;
      endcase
   end

   always_comb begin
      rx_valid       = 1'b0;
      rx_last        = 1'b0;
      rx_data        = '0;
      w_pop          = 1'b0;
      w_rx_dest_err  = 1'b0;
      w_rx_proto_err = 1'b0;
      w_rx_done      = 1'b0;
      w_head_take    = 1'b0;
      case (r_rx_state)
         RX_WAIT_HEAD: if (!w_empty) begin
            w_pop = 1'b1;
            if (!w_is_head)      w_rx_proto_err = 1'b1;
            else if (!w_dest_ok) w_rx_dest_err  = 1'b1;
            else begin
               w_head_take = 1'b1;
               w_rx_done   = (w_ftype == FLIT_SINGLE);
            end
         end
         RX_DELIVER: if (!w_empty) begin
            if (w_is_head) begin
               w_pop          = 1'b1;
               w_rx_proto_err = 1'b1;
            end else begin
               rx_valid  = 1'b1;
               rx_data   = w_fpay;
               rx_last   = (w_ftype == FLIT_TAIL);
               w_pop     = rx_ready;
               w_rx_done = rx_ready && (w_ftype == FLIT_TAIL);
            end
         end
         RX_DROP: if (!w_empty) w_pop = 1'b1;
         default: ;
      endcase
   end

   // SINGLE completes in the cycle its head is seen, so its ts comes off the FIFO
   assign w_done_ts = (r_rx_state == RX_WAIT_HEAD) ? w_fpay[HF_TS +: TS_WIDTH] : r_rx_ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_sx    <= '0;
         r_rx_sy    <= '0;
         r_rx_len   <= '0;
         r_rx_ts    <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_head_take) begin
            r_rx_sx  <= w_fpay[HF_SRC_X +: CW];
            r_rx_sy  <= w_fpay[HF_SRC_Y +: CW];
            r_rx_len <= w_fpay[HF_LEN +: LW];
            r_rx_ts  <= w_fpay[HF_TS +: TS_WIDTH];
         end
         if (w_rx_done) r_rx_count <= r_rx_count + 1'b1;
      end
   end

   // ---------------------------------------------------- errors and status
   always_comb begin
      w_err_set                    = '0;
      w_err_set[ERR_DEST_MISMATCH] = w_rx_dest_err;
      w_err_set[ERR_PROTOCOL]      = w_rx_proto_err;
      w_err_set[ERR_BAD_LEN]       = tx_req_valid && tx_req_ready && w_bad_len;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err <= '0;
      else     r_err <= (err_clr ? 32'd0 : r_err) | w_err_set;
   end

`ifdef NEBULA_BRIDGE_LATENCY_EN
   logic [TS_WIDTH-1:0]        r_ts_cnt, r_avg, w_lat;
   logic                       r_lat_seen;
   logic signed [TS_WIDTH:0]   w_diff, w_step;

   assign w_head_ts = r_ts_cnt + 1'b1;
   assign w_lat     = r_ts_cnt - w_done_ts;
   assign w_diff    = $signed({1'b0, w_lat}) - $signed({1'b0, r_avg});
   assign w_step    = w_diff >>> 3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ts_cnt   <= '0;
         r_avg      <= '0;
         r_lat_seen <= 1'b0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 1'b1;
         if (w_rx_done) begin
            r_lat_seen <= 1'b1;
            r_avg      <= r_lat_seen ? (r_avg + w_step[TS_WIDTH-1:0]) : w_lat;
         end
      end
   end

   assign avg_latency = 16'(r_avg);
`else
   logic w_unused_ts;

   assign w_head_ts   = '0;
   assign avg_latency = '0;
   assign w_unused_ts = ^w_done_ts;
`endif

   logic w_unused;
   assign w_unused = ^r_rx_len;

   assign rx_src_x           = r_rx_sx;
   assign rx_src_y           = r_rx_sy;
   assign packet_tx_count    = r_tx_count;
   assign packet_rx_count    = r_rx_count;
   assign buffer_utilization = 8'(w_count);
   assign error_reg          = r_err;

endmodule
`default_nettype wire
